// File: rtl/cordic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_pkg : shared state encoding and arctangent table for the CORDIC   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package cordic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } cordic_state_e;

   // atan(2^-i) as a binary angle where the full circle is 2^32
   localparam logic [31:0] ATAN32 [0:31] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
   };

   function automatic logic [31:0] atan_entry(input logic [4:0] i, input int width);
      logic [32:0] w_sum;
      if (width >= 32) begin
         return ATAN32[i];
      end
      w_sum = {1'b0, ATAN32[i]} + (33'd1 << (31 - width));
      return 32'(w_sum >> (32 - width));
   endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_shifter : arithmetic (floor-rounding) right barrel shifter        |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module cordic_shifter
   import cordic_pkg::*;
#(
   parameter int N  = 18,
   parameter int SW = 4
) (
   input  logic signed [N-1:0]  i_data,
   input  logic        [SW-1:0] i_shamt,
   output logic signed [N-1:0]  o_data
);

   assign o_data = i_data >>> i_shamt;

endmodule
`default_nettype wire

// File: rtl/cordic_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_engine : iterative rotation/vectoring CORDIC, full-circle angles  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module cordic_engine
   import cordic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ITER  = 14
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [WIDTH-1:0]   x_in,
   input  logic [WIDTH-1:0]   y_in,
   input  logic [WIDTH-1:0]   z_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH+1:0]   x_out,
   output logic [WIDTH+1:0]   y_out,
   output logic [WIDTH-1:0]   z_out,
   output logic               busy
);

   localparam int XW = WIDTH + 2;
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   cordic_state_e          r_state, w_next;
   logic [CW-1:0]          r_cnt;
   logic                   r_mode;
   logic signed [XW-1:0]   r_x, r_y, r_xo, r_yo;
   logic [WIDTH-1:0]       r_z, r_zo;

   logic                   w_accept, w_last, w_flip, w_d;
   logic signed [XW-1:0]   w_xe, w_ye, w_x0, w_y0, w_xs, w_ys, w_xn, w_yn;
   logic [WIDTH-1:0]       w_z0, w_zn, w_atan;
   logic [WIDTH-1:0]       w_atan_tab [0:ITER-1];

   for (genvar i = 0; i < ITER; i++) begin : g_atan
      assign w_atan_tab[i] = WIDTH'(atan_entry(5'(i), WIDTH));
   end

   assign w_atan   = w_atan_tab[r_cnt];
   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_cnt == CW'(ITER - 1));

   cordic_shifter #(.N(XW), .SW(CW)) u_shift_x (
      .i_data  (r_x),
      .i_shamt (r_cnt),
      .o_data  (w_xs)
   );

   cordic_shifter #(.N(XW), .SW(CW)) u_shift_y (
      .i_data  (r_y),
      .i_shamt (r_cnt),
      .o_data  (w_ys)
   );

   // Half-turn pre-rotation brings every operand into the convergence range
   assign w_flip = mode ? x_in[WIDTH-1] : (z_in[WIDTH-1] ^ z_in[WIDTH-2]);
   assign w_xe   = {{2{x_in[WIDTH-1]}}, x_in};
   assign w_ye   = {{2{y_in[WIDTH-1]}}, y_in};
   assign w_x0   = w_flip ? -w_xe : w_xe;
   assign w_y0   = w_flip ? -w_ye : w_ye;
   assign w_z0   = w_flip ? {~z_in[WIDTH-1], z_in[WIDTH-2:0]} : z_in;

   assign w_d  = r_mode ? r_y[XW-1] : ~r_z[WIDTH-1];
   assign w_xn = w_d ? (r_x - w_ys)    : (r_x + w_ys);
   assign w_yn = w_d ? (r_y + w_xs)    : (r_y - w_xs);
   assign w_zn = w_d ? (r_z - w_atan)  : (r_z + w_atan);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_ITER;
         ST_ITER: if (w_last)   w_next = ST_DONE;
         ST_DONE: begin
            if (w_accept) begin
               w_next = ST_ITER;
            end else if (out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = reset & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
      out_valid = (r_state == ST_DONE);
      busy      = (r_state != ST_IDLE);
   end

   // Results are latched only on the final micro-rotation so they hold through stalls
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_mode <= 1'b0;
         r_cnt  <= '0;
         r_xo   <= '0;
         r_yo   <= '0;
         r_zo   <= '0;
      end else if (w_accept) begin
         r_x    <= w_x0;
         r_y    <= w_y0;
         r_z    <= w_z0;
         r_mode <= mode;
         r_cnt  <= '0;
      end else if (r_state == ST_ITER) begin
         r_x   <= w_xn;
         r_y   <= w_yn;
         r_z   <= w_zn;
         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
         if (w_last) begin
            r_xo <= w_xn;
            r_yo <= w_yn;
            r_zo <= w_zn;
         end
      end
   end

   assign x_out = r_xo;
   assign y_out = r_yo;
   assign z_out = r_zo;

endmodule
`default_nettype wire
